cond_logic: RTL and testbench
=============================

Name: cond_logic

Overview:
- Conditional-execution stage sitting directly downstream of main_decoder and the ALU decoder in the single-cycle control unit.
- Holds the architectural NZCV flags register and evaluates the instruction's 4-bit condition field against it.
- Gates the decoder's raw write strobes (reg_w, mem_w, pc_s) into the committed strobes that drive the register file, data memory and PC mux.
- Updates the flags from the ALU under per-group write enables.

Parameters:
- FLAG_W, 4, number of architectural flags (N,Z,C,V); fixed, exposed for package consistency.
- COND_W, 4, width of the instruction condition field.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  pipeline/core enable; 0 = stall, no flag update.
- cond  input  4  instruction condition field, Instr[31:28].
- alu_flags  input  4  ALU result flags {N,Z,C,V}, same cycle.
- flag_w  input  2  from ALU decoder; [1] = update N,Z; [0] = update C,V.
- pc_s  input  1  decoder: instruction writes PC (branch, or write to R15).
- reg_w  input  1  raw register-write strobe from main_decoder.
- mem_w  input  1  raw memory-write strobe from main_decoder.
- no_w  input  1  compare-class op: suppress register write regardless of condition.
- pc_src  output  1  committed PC-source select.
- reg_write  output  1  committed register-file write enable.
- mem_write  output  1  committed data-memory write enable.
- cond_ex  output  1  condition passed for the current instruction.
- flags  output  4  current registered {N,Z,C,V}.

Behaviour:
- Reset: flags <= 4'b0000 immediately on rst rising, independent of clk. While rst=1, cond_ex forced 0, so pc_src, reg_write and mem_write are all 0.
- cond_ex is combinational from cond and the registered flags (pre-update values of this cycle). Zero latency.
- Condition table:
  - 0000 EQ: Z. 0001 NE: !Z. 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N. 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !C|Z. 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: Z|(N!=V). 1110 AL: 1.
  - 1111: reserved; cond_ex=0.
- Committed strobes:
  - pc_src = pc_s & cond_ex.
  - reg_write = reg_w & cond_ex & !no_w.
  - mem_write = mem_w & cond_ex.
- Flag update on rising clk, when !rst & en & cond_ex:
  - flag_w[1] set: N,Z <= alu_flags[3:2].
  - flag_w[0] set: C,V <= alu_flags[1:0].
  - Groups are independent; a group whose enable is 0 holds its value.
- en=0: flags hold. Combinational outputs still follow inputs; the stall owner is responsible for masking.
- A failed condition never updates flags, even when flag_w is nonzero.
- Simultaneous read and update: the condition uses old flags; new flags are visible to the next instruction only.
- Reset asserted mid-cycle clears flags at once; the first instruction after rst deasserts sees NZCV=0000.

Decomposition:
- cond_pkg:
  - enum cond_t (EQ..AL, NV=4'b1111).
  - localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - flag_w group indices FW_NZ=1, FW_CV=0.
- Sub-module cond_check: purely combinational (cond, flags) -> cond_ex. Instantiated once here and reusable by a future pipelined hazard unit.
- Top module holds the flags register and the gating logic.

Test Plan:
- Reset: assert rst mid-cycle with flags=1111 -> flags=0000 before the next clk edge; cond=1110, reg_w=1 gives reg_write=0 while rst=1 and 1 after release.
- Flag write and EQ/NE: alu_flags=0100, flag_w=10, cond=1110, edge -> flags=0100. Next cycle cond=0000, pc_s=1 -> pc_src=1; cond=0001 -> pc_src=0.
- Partial update: flags=0100, alu_flags=1011, flag_w=01, edge -> flags=0111 (N,Z held, C,V loaded).
- Failed condition: flags=0000, cond=0000, mem_w=1, flag_w=11, alu_flags=1111 -> mem_write=0; flags stay 0000 after edge.
- Signed compares with no_w: flags=1000 (N!=V), cond=1011 LT, reg_w=1, no_w=1 -> cond_ex=1, reg_write=0. Same flags with cond=1010 GE -> cond_ex=0. Flags=1001 with cond=1100 GT -> cond_ex=1.
- Stall and reserved code: en=0, flag_w=11, alu_flags=1111, cond=1110 -> flags unchanged after edge. cond=1111 with reg_w=1 -> reg_write=0.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-execution stage.
// Condition codes, NZCV flag bit positions and flag-write group indices.
package cond_pkg;

  localparam int FLAG_W = 4;
  localparam int COND_W = 4;

  typedef enum logic [COND_W-1:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: (cond, flags) -> pass.
// Ports: cond 4b in, flags {N,Z,C,V} in, pass out. NV always fails.
module cond_check
  import cond_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    unique case (cond_t'(cond))
      EQ: pass = z;
      NE: pass = !z;
      CS: pass = c;
      CC: pass = !c;
      MI: pass = n;
      PL: pass = !n;
      VS: pass = v;
      VC: pass = !v;
      HI: pass = c & !z;
      LS: pass = !c | z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = !z & (n == v);
      LE: pass = z | (n != v);
      AL: pass = 1'b1;
      NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: NZCV register, condition check, strobe gating.
// In: clk rst en cond alu_flags flag_w pc_s reg_w mem_w no_w; out: pc_src reg_write mem_write cond_ex flags.
module cond_logic
  import cond_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [COND_W-1:0] cond,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [1:0]        flag_w,
  input  logic              pc_s,
  input  logic              reg_w,
  input  logic              mem_w,
  input  logic              no_w,
  output logic              pc_src,
  output logic              reg_write,
  output logic              mem_write,
  output logic              cond_ex,
  output logic [FLAG_W-1:0] flags
);

  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] flags_d;
  logic              pass;

  // Evaluated against the registered (pre-update) flags.
  cond_check u_check (
    .cond  (cond),
    .flags (flags_q),
    .pass  (pass)
  );

  // Reset masks every committed strobe, not just the flags.
  assign cond_ex   = pass & !rst;
  assign pc_src    = pc_s & cond_ex;
  assign reg_write = reg_w & cond_ex & !no_w;
  assign mem_write = mem_w & cond_ex;
  assign flags     = flags_q;

  always_comb begin
    flags_d = flags_q;
    if (en && cond_ex) begin
      if (flag_w[FW_NZ]) begin
        flags_d[FLAG_N] = alu_flags[FLAG_N];
        flags_d[FLAG_Z] = alu_flags[FLAG_Z];
      end
      if (flag_w[FW_CV]) begin
        flags_d[FLAG_C] = alu_flags[FLAG_C];
        flags_d[FLAG_V] = alu_flags[FLAG_V];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic.
// Directed vectors; inputs change 1ns after posedge, outputs sampled mid-cycle.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic [1:0] flag_w;
  logic       pc_s, reg_w, mem_w, no_w;
  logic       pc_src, reg_write, mem_write, cond_ex;
  logic [3:0] flags;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cond_logic dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cond      (cond),
    .alu_flags (alu_flags),
    .flag_w    (flag_w),
    .pc_s      (pc_s),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .no_w      (no_w),
    .pc_src    (pc_src),
    .reg_write (reg_write),
    .mem_write (mem_write),
    .cond_ex   (cond_ex),
    .flags     (flags)
  );

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_flags(input logic [3:0] f);
    en        = 1'b1;
    cond      = 4'b1110;
    flag_w    = 2'b11;
    alu_flags = f;
    tick();
    flag_w    = 2'b00;
    alu_flags = 4'b0000;
  endtask

  task automatic sweep(input string tag, input logic [15:0] exp);
    logic [15:0] got;
    for (int i = 0; i < 16; i++) begin
      cond = 4'(i);
      #1;
      got[i] = cond_ex;
    end
    check(tag, got, exp);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; cond = 4'b1110;
    alu_flags = 4'b0000; flag_w = 2'b00;
    pc_s = 1'b0; reg_w = 1'b1; mem_w = 1'b0; no_w = 1'b0;
    tick();
    #2;
    check("rst_flags", 16'(flags), 16'h0);
    check("rst_regwr", 16'(reg_write), 16'h0);
    rst = 1'b0;
    #1;
    check("rel_regwr", 16'(reg_write), 16'h1);
    reg_w = 1'b0;

    load_flags(4'b1111);
    check("load_1111", 16'(flags), 16'hF);
    #2;
    rst = 1'b1;
    reg_w = 1'b1;
    #1;
    check("async_rst", 16'(flags), 16'h0);
    check("rst_mask", 16'({pc_src, reg_write, mem_write, cond_ex}), 16'h0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst", 16'({reg_write, cond_ex}), 16'h3);
    reg_w = 1'b0;

    cond = 4'b1110; alu_flags = 4'b0100; flag_w = 2'b10;
    tick();
    check("nz_write", 16'(flags), 16'h4);
    flag_w = 2'b00; alu_flags = 4'b0000;
    cond = 4'b0000; pc_s = 1'b1;
    #1;
    check("eq_pc", 16'(pc_src), 16'h1);
    cond = 4'b0001;
    #1;
    check("ne_pc", 16'(pc_src), 16'h0);
    pc_s = 1'b0;

    cond = 4'b1110; alu_flags = 4'b1011; flag_w = 2'b01;
    tick();
    check("cv_write", 16'(flags), 16'h7);

    load_flags(4'b0000);
    cond = 4'b0000; mem_w = 1'b1;
    flag_w = 2'b11; alu_flags = 4'b1111;
    #1;
    check("fail_memw", 16'(mem_write), 16'h0);
    tick();
    check("fail_hold", 16'(flags), 16'h0);
    mem_w = 1'b0;

    load_flags(4'b1000);
    cond = 4'b1011; reg_w = 1'b1; no_w = 1'b1;
    #1;
    check("lt_ex", 16'(cond_ex), 16'h1);
    check("lt_now", 16'(reg_write), 16'h0);
    no_w = 1'b0;
    #1;
    check("lt_regw", 16'(reg_write), 16'h1);
    cond = 4'b1010;
    #1;
    check("ge_ex", 16'(cond_ex), 16'h0);
    reg_w = 1'b0;

    load_flags(4'b1001);
    cond = 4'b1100;
    #1;
    check("gt_ex", 16'(cond_ex), 16'h1);
    sweep("sweep_1001", 16'h565A);

    en = 1'b0; flag_w = 2'b11;
    alu_flags = 4'b1111; cond = 4'b1110;
    tick();
    check("stall", 16'(flags), 16'h9);
    en = 1'b1; flag_w = 2'b00;
    cond = 4'b1111; reg_w = 1'b1;
    #1;
    check("nv_regw", 16'(reg_write), 16'h0);
    reg_w = 1'b0;

    load_flags(4'b0110);
    sweep("sweep_0110", 16'h66A5);
    load_flags(4'b1010);
    sweep("sweep_1010", 16'h6996);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
